// File: rtl/sudoku_ram_arbiter.sv
// Three-way arbiter for one game-RAM port: L fixed priority, C/K round-robin.
// Optional SUDOKU_ARB_WRLOCK_EN suppresses C/K writes while wr_lock is high.
module sudoku_ram_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              l_req,
    input  logic              c_req,
    input  logic              k_req,
    input  logic              l_we,
    input  logic              c_we,
    input  logic              k_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [ADDR_W-1:0] k_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] k_wdata,
    output logic              l_ack,
    output logic              c_ack,
    output logic              k_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
`ifdef SUDOKU_ARB_WRLOCK_EN
    input  logic              wr_lock,
    output logic              wr_blocked,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {OWN_L, OWN_C, OWN_K} own_t;

    state_t state, state_nx;
    own_t   owner, grant;

    logic              any_req;
    logic              rr_k;
    logic              wr;
    logic              lock_hit;
    logic              resp;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign any_req = l_req | c_req | k_req;

    // rr_k set means K was the last C/K grant, so C wins the next tie
    always_comb begin
        grant = OWN_L;
        if (l_req)
            grant = OWN_L;
        else if (c_req && k_req)
            grant = rr_k ? OWN_C : OWN_K;
        else if (c_req)
            grant = OWN_C;
        else
            grant = OWN_K;
    end

    always_comb begin
        sel_we   = l_we;
        sel_addr = l_addr;
        sel_data = l_wdata;
        case (grant)
            OWN_C: begin
                sel_we   = c_we;
                sel_addr = c_addr;
                sel_data = c_wdata;
            end
            OWN_K: begin
                sel_we   = k_we;
                sel_addr = k_addr;
                sel_data = k_wdata;
            end
            default: begin
                sel_we   = l_we;
                sel_addr = l_addr;
                sel_data = l_wdata;
            end
        endcase
    end

`ifdef SUDOKU_ARB_WRLOCK_EN
    logic blk;
    assign lock_hit = wr_lock && (grant != OWN_L);
`else
    assign lock_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = any_req ? ACCESS : IDLE;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant capture; address and data hold their value between accesses
    always_ff @(posedge CLK) begin
        if (RST) begin
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            owner    <= OWN_L;
            wr       <= 1'b0;
            rr_k     <= 1'b1;
`ifdef SUDOKU_ARB_WRLOCK_EN
            blk      <= 1'b0;
`endif
        end else if (state == IDLE && any_req) begin
            ram_addr <= sel_addr;
            ram_data <= sel_data;
            ram_wren <= sel_we && !lock_hit;
            owner    <= grant;
            wr       <= sel_we;
            if (grant != OWN_L)
                rr_k <= (grant == OWN_K);
`ifdef SUDOKU_ARB_WRLOCK_EN
            blk      <= sel_we && lock_hit;
`endif
        end else begin
            ram_wren <= 1'b0;
        end
    end

    // Acks are masked by RST so a reset in RESP never completes the access
    always_comb begin
        busy  = (state != IDLE);
        resp  = (state == RESP) && !RST;
        l_ack = resp && (owner == OWN_L);
        c_ack = resp && (owner == OWN_C);
        k_ack = resp && (owner == OWN_K);
        rdata = (resp && !wr) ? ram_q : '0;
`ifdef SUDOKU_ARB_WRLOCK_EN
        wr_blocked = resp && blk;
`endif
    end

endmodule
